reg_file_dump_reader: RTL
=========================

// Module: reg_file_dump_reader
// PURPOSE
//  Read-side sequencer for Register_File: on a start pulse, walks read port 1
//  from FIRST_ADDR to LAST_ADDR and delivers each (address, data) pair on a
//  valid/ready stream with a running XOR checksum. Used for debug dump and
//  architectural-state comparison after a test program. Does not drive write port.
// PARAMETERS
//  ADDR_W      5    register address width
//  DATA_W      32   register data width
//  FIRST_ADDR  0    first register read (must be <= LAST_ADDR)
//  LAST_ADDR   31   last register read
// PORTS
//  clk       in   1       rising-edge clock, shared with Register_File
//  rst       in   1       asynchronous active-high reset
//  start     in   1       begin a dump; sampled only in IDLE
//  busy      out  1       high in READ or HOLD
//  done      out  1       one-cycle pulse after last word is accepted
//  rf_ra     out  ADDR_W  to Register_File RA1
//  rf_rd     in   DATA_W  from Register_File RD1 (combinational read)
//  out_valid out  1       out_addr/out_data hold a word
//  out_ready in   1       sink accepts word when out_valid && out_ready
//  out_addr  out  ADDR_W  register index of current word
//  out_data  out  DATA_W  register contents of current word
//  checksum  out  DATA_W  XOR of all words delivered in current/last dump
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ptr=FIRST_ADDR; busy, done,
//    out_valid=0; out_addr, out_data, checksum=0; rf_ra=FIRST_ADDR.
//  - FSM states IDLE, READ, HOLD, DONE; all outputs registered except
//    rf_ra=ptr (from register ptr) and busy (decoded from state).
//  - IDLE: start=1 at edge -> READ; ptr<=FIRST_ADDR; checksum<=0. Else stay.
//  - READ (1 cycle): rf_ra=ptr; at edge: out_data<=rf_rd, out_addr<=ptr,
//    checksum<=checksum^rf_rd, out_valid<=1, -> HOLD.
//  - HOLD: out_valid=1; out_addr/out_data/rf_ra stable while out_ready=0
//    (unbounded stall). On out_valid&&out_ready at edge: out_valid<=0;
//    if ptr==LAST_ADDR -> DONE, else ptr<=ptr+1, -> READ.
//  - DONE (1 cycle): done=1 -> IDLE. checksum holds until next start.
//  - Latency: start sampled at edge E0; word k valid after E(1+2k); with
//    out_ready=1 handshake at E(2+2k); done high after E(2N), N=LAST-FIRST+1;
//    back in IDLE after E(2N+1). Max throughput 1 word / 2 cycles.
//  - start while busy or in DONE: ignored, no restart.
//  - Data is sampled in the READ cycle; a write to the same register at that
//    same edge is not seen (RD is pre-write); writes to later registers
//    before their READ cycle are seen.
//  - FIRST_ADDR==LAST_ADDR: single word, done after E2. ptr never wraps;
//    compare is exact equality, width ADDR_W.
//  - Reset mid-dump: immediate abort, no done pulse, partial checksum lost.
// TESTING
//  1 Write all 32 regs 0, then x1=12345678, x2=87654321; start, ready=1 ->
//    32 words addr 0..31 in order, addr1=12345678, addr2=87654321, others 0;
//    done one cycle after E64; checksum=12345678^87654321.
//  2 Backpressure: ready=0 for 5 cycles on word 1 -> out_valid stays 1,
//    out_addr=1, out_data=12345678, rf_ra=1 constant; no word lost/duplicated.
//  3 start pulsed again at word 10 -> ignored; exactly 32 words, one done.
//  4 Assert rst while out_valid=1 on word 5 -> out_valid, busy, checksum drop
//    to 0 immediately (before next edge); no done; new start dumps from 0.
//  5 During dump, write x20=0xDEADBEEF while word 3 pending -> word 20 reads
//    0xDEADBEEF; checksum includes it.
//  6 FIRST_ADDR=LAST_ADDR=7, x7=0x55 -> one word addr 7 data 0x55, done
//    after E2, checksum=0x55.

Source files
------------

// File: rtl/reg_file_dump_reader_if.sv
// Signal bundle between the dump reader, the register-file read port 1 and the
// downstream valid/ready sink.
interface reg_file_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_ra;
    logic [DATA_W-1:0] rf_rd;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] checksum;

    modport master (
        input  start, rf_rd, out_ready,
        output busy, done, rf_ra, out_valid, out_addr, out_data, checksum
    );

    modport slave (
        output start, rf_rd, out_ready,
        input  busy, done, rf_ra, out_valid, out_addr, out_data, checksum
    );
endinterface

// File: rtl/reg_file_dump_reader.sv
// Walks Register_File read port 1 from FIRST_ADDR to LAST_ADDR and streams each
// (address, data) pair out on a valid/ready port with a running XOR checksum.
module reg_file_dump_reader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_file_dump_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              accept;
    logic              at_last;

    assign accept  = out_valid_q && bus.out_ready;
    assign at_last = (ptr_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= FIRST;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // start is only honoured from IDLE, so a pulse mid-dump cannot restart the walk
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = READ;
            READ:    state_d = HOLD;
            HOLD:    if (accept) state_d = at_last ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d      = FIRST;
                    checksum_d = '0;
                end
            end
            READ: begin
                out_data_d  = bus.rf_rd;
                out_addr_d  = ptr_q;
                checksum_d  = checksum_q ^ bus.rf_rd;
                out_valid_d = 1'b1;
            end
            HOLD: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    // ptr stops at LAST so it never wraps past the end of the range
                    if (at_last) done_d = 1'b1;
                    else         ptr_d  = ptr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_q == READ) || (state_q == HOLD);
    assign bus.done      = done_q;
    assign bus.rf_ra     = ptr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.checksum  = checksum_q;
endmodule
